// File: rtl/product_shift_reg.sv
// product_shift_reg
//   2W-bit product register for shift-and-add multipliers and similar
//   iterative datapaths. Either half can be loaded in parallel, and the whole
//   register can shift right by one. A load and a shift in the same cycle form
//   one add-then-shift step. An iteration counter counts shifts since the last
//   start. It saturates at W, and done is raised on the same edge that count
//   reaches W.
//
// Parameters
//   W       half width (register is 2W bits)
//   SIGNED  0: MSB filled from cin on shift; 1: sign bit replicated
//
// Ports
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset of out/count/done
//   sclr     synchronous clear (highest priority)
//   start    restart counter; loads still apply, shift ignored
//   loadh    load upper half from inh
//   loadl    load lower half from inl
//   inh/inl  half-width load data
//   shift    shift right by one (ignored once done)
//   cin      MSB fill bit when SIGNED=0
//   out      registered 2W-bit contents
//   count    registered shift count since start, 0..W
//   done     registered, high when count==W
module product_shift_reg #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   sclr,
  input  logic                   start,
  input  logic                   loadh,
  input  logic                   loadl,
  input  logic [W-1:0]           inh,
  input  logic [W-1:0]           inl,
  input  logic                   shift,
  input  logic                   cin,
  output logic [2*W-1:0]         out,
  output logic [$clog2(W+1)-1:0] count,
  output logic                   done
);

  localparam int             CW   = $clog2(W+1);
  localparam logic [CW-1:0]  CMAX = CW'(W);

  logic [2*W-1:0] out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [2*W-1:0] pre;     // value after any half loads, before shift
  logic           fill;    // bit entering the MSB on a shift
  logic           do_shift;
  logic [CW-1:0]  cnt_inc;

  // Pre-shift value: each half independently takes load data or holds.
  always_comb begin
    pre = out_q;
    if (loadh) pre[2*W-1:W] = inh;
    if (loadl) pre[W-1:0]   = inl;
  end

  // In signed mode the sign of the pre-shift value is replicated. A same-cycle
  // load of the upper half therefore supplies the sign.
  assign fill     = SIGNED ? pre[2*W-1] : cin;
  // A start cycle never shifts. A saturated counter freezes the data shift.
  assign do_shift = shift & ~start & ~done_q;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    out_d  = pre;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (sclr) begin
      out_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (start) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (do_shift) begin
      out_d  = {fill, pre[2*W-1:1]};
      cnt_d  = cnt_inc;
      // done is decoded from the next count, so it rises with count at zero
      // added latency.
      done_d = (cnt_inc == CMAX);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign out   = out_q;
  assign count = cnt_q;
  assign done  = done_q;

endmodule

// File: tb/tb_product_shift_reg.sv
module tb_product_shift_reg;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            clear_n, sclr, start, loadh, loadl, shift, cin;
  logic [W-1:0]    inh, inl;
  logic [2*W-1:0]  out0, out1;
  logic [3:0]      count0, count1;
  logic            done0, done1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] out0;
    logic [3:0]  cnt0;
    logic        done0;
    logic        chk1;
    logic [15:0] out1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  product_shift_reg #(.W(W), .SIGNED(1'b0)) u0 (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .start(start),
    .loadh(loadh), .loadl(loadl), .inh(inh), .inl(inl),
    .shift(shift), .cin(cin), .out(out0), .count(count0), .done(done0)
  );

  product_shift_reg #(.W(W), .SIGNED(1'b1)) u1 (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .start(start),
    .loadh(loadh), .loadl(loadl), .inh(inh), .inl(inl),
    .shift(shift), .cin(cin), .out(out1), .count(count1), .done(done1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, record the expectation, then pop it
  // and compare just after the rising edge.
  task automatic step(input string tag,
                      input logic s_sclr, input logic s_start,
                      input logic s_lh, input logic [7:0] s_inh,
                      input logic s_ll, input logic [7:0] s_inl,
                      input logic s_shift, input logic s_cin,
                      input logic [15:0] e_out, input logic [3:0] e_cnt,
                      input logic e_done,
                      input logic e_chk1 = 1'b0, input logic [15:0] e_out1 = '0);
    exp_t e;
    @(negedge clk);
    sclr = s_sclr; start = s_start; loadh = s_lh; inh = s_inh;
    loadl = s_ll; inl = s_inl; shift = s_shift; cin = s_cin;
    e.tag = tag; e.out0 = e_out; e.cnt0 = e_cnt; e.done0 = e_done;
    e.chk1 = e_chk1; e.out1 = e_out1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_out"},   out0,            e.out0);
      check({e.tag, "_count"}, {12'h0, count0}, {12'h0, e.cnt0});
      check({e.tag, "_done"},  {15'h0, done0},  {15'h0, e.done0});
      if (e.chk1) check({e.tag, "_sout"}, out1, e.out1);
    end
  endtask

  initial begin
    logic [15:0] e;
    clear_n = 1'b0; sclr = 0; start = 0; loadh = 0; loadl = 0;
    inh = '0; inl = '0; shift = 0; cin = 0;
    #3;
    check("rst_out",   out0,            16'h0000);
    check("rst_count", {12'h0, count0}, 16'h0000);
    check("rst_done",  {15'h0, done0},  16'h0000);
    @(negedge clk);
    clear_n = 1'b1;

    // idle after reset release: holds zero
    step("idle", 0,0, 0,8'h00, 0,8'h00, 0,0, 16'h0000, 4'd0, 1'b0);

    // load both halves, then lower only
    step("load_both", 0,0, 1,8'hA5, 1,8'h3C, 0,0, 16'hA53C, 4'd0, 1'b0);
    step("load_lo",   0,0, 0,8'h00, 1,8'hFF, 0,0, 16'hA5FF, 4'd0, 1'b0);

    // unsigned fill from cin; signed instance ignores cin and keeps sign 0
    step("sclr0",     1,0, 0,8'h00, 0,8'h00, 0,0, 16'h0000, 4'd0, 1'b0);
    step("ld0001",    0,0, 0,8'h00, 1,8'h01, 0,0, 16'h0001, 4'd0, 1'b0, 1'b1, 16'h0001);
    step("fill_cin",  0,0, 0,8'h00, 0,8'h00, 1,1, 16'h8000, 4'd1, 1'b0, 1'b1, 16'h0000);
    // signed fill: 0x8000 -> 0xC000; unsigned with cin=0 -> 0x4000
    step("ld8000",    0,1, 1,8'h80, 1,8'h00, 0,0, 16'h8000, 4'd0, 1'b0, 1'b1, 16'h8000);
    step("fill_sign", 0,0, 0,8'h00, 0,8'h00, 1,0, 16'h4000, 4'd1, 1'b0, 1'b1, 16'hC000);

    // combined load + shift in one edge
    step("ld0003",    0,1, 1,8'h00, 1,8'h03, 0,0, 16'h0003, 4'd0, 1'b0);
    step("add_shift", 0,0, 1,8'h12, 0,8'h00, 1,0, 16'h0901, 4'd1, 1'b0);

    // eight shifts to done, then saturation
    step("cnt_start", 0,1, 1,8'h80, 1,8'h00, 1,1, 16'h8000, 4'd0, 1'b0);
    e = 16'h8000;
    for (int k = 1; k <= 8; k++) begin
      e = {1'b1, e[15:1]};
      step($sformatf("cnt_sh%0d", k), 0,0, 0,8'h00, 0,8'h00, 1,1,
           e, 4'(k), (k == 8));
    end
    step("cnt_sat",   0,0, 0,8'h00, 0,8'h00, 1,1, 16'hFF80, 4'd8, 1'b1);
    step("done_load", 0,0, 0,8'h00, 1,8'h55, 1,1, 16'hFF55, 4'd8, 1'b1);

    // priority: sclr beats everything; start suppresses shift
    step("sclr_pri",  1,1, 1,8'hFF, 0,8'h00, 1,1, 16'h0000, 4'd0, 1'b0);
    step("ld1234",    0,0, 1,8'h12, 1,8'h34, 0,0, 16'h1234, 4'd0, 1'b0);
    step("start_sh",  0,1, 0,8'h00, 0,8'h00, 1,1, 16'h1234, 4'd0, 1'b0);
    step("sh_1234",   0,0, 0,8'h00, 0,8'h00, 1,0, 16'h091A, 4'd1, 1'b0);

    // reach count=5, reload 0x1234, then async clear between edges
    step("sh2", 0,0, 0,8'h00, 0,8'h00, 1,0, 16'h048D, 4'd2, 1'b0);
    step("sh3", 0,0, 0,8'h00, 0,8'h00, 1,0, 16'h0246, 4'd3, 1'b0);
    step("sh4", 0,0, 0,8'h00, 0,8'h00, 1,0, 16'h0123, 4'd4, 1'b0);
    step("sh5", 0,0, 0,8'h00, 0,8'h00, 1,0, 16'h0091, 4'd5, 1'b0);
    step("reld1234", 0,0, 1,8'h12, 1,8'h34, 0,0, 16'h1234, 4'd5, 1'b0);
    @(negedge clk);
    loadh = 0; loadl = 0; shift = 0;
    clear_n = 1'b0;
    #1;
    check("arst_out",   out0,            16'h0000);
    check("arst_count", {12'h0, count0}, 16'h0000);
    check("arst_done",  {15'h0, done0},  16'h0000);
    #1;
    clear_n = 1'b1;

    // after release state holds; first shift behaves normally
    step("post_hold",  0,0, 0,8'h00, 0,8'h00, 0,0, 16'h0000, 4'd0, 1'b0);
    step("post_shift", 0,0, 0,8'h00, 0,8'h00, 1,1, 16'h8000, 4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_shift_reg.md
PRODUCT_SHIFT_REG -- requirements
Module: product_shift_reg

Interface
REQ-001 SHALL have parameter W, default 8: half width; the register is 2W bits.
REQ-002 SHALL have parameter SIGNED, default 0: 0 = MSB fill from cin on shift, 1 = arithmetic fill (sign replicate).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port clear_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sclr  input  1  synchronous clear of data, counter and done.
REQ-006 SHALL have port start  input  1  restart iteration counter.
REQ-007 SHALL have port loadh  input  1  load upper half from inh.
REQ-008 SHALL have port loadl  input  1  load lower half from inl.
REQ-009 SHALL have port inh  input  W  upper-half load data.
REQ-010 SHALL have port inl  input  W  lower-half load data.
REQ-011 SHALL have port shift  input  1  shift full 2W register right by one.
REQ-012 SHALL have port cin  input  1  MSB fill bit on shift when SIGNED=0.
REQ-013 SHALL have port out  output  2W  registered contents.
REQ-014 SHALL have port count  output  $clog2(W+1)  shifts done since start.
REQ-015 SHALL have port done  output  1  registered; high when count==W.

Function
REQ-016 SHALL update all state on rising clk only, except asynchronous reset.
REQ-017 SHALL apply per-cycle priority: sclr > start > load/shift > hold.
REQ-018 sclr=1 SHALL force out=0, count=0, done=0 next edge, ignoring all other inputs.
REQ-019 start=1 (sclr=0) SHALL set count=0, done=0; loadh/loadl SHALL still apply that cycle; shift SHALL be ignored that cycle.
REQ-020 SHALL form pre-shift value P = {loadh ? inh : out[2W-1:W], loadl ? inl : out[W-1:0]}.
REQ-021 With shift=0, out SHALL become P; unloaded half holds.
REQ-022 With shift=1 and done=0, out SHALL become {F, P[2W-1:1]}, F = cin when SIGNED=0, F = P[2W-1] when SIGNED=1; count SHALL increment by 1.
REQ-023 Load and shift in the same cycle SHALL combine per REQ-020/022 in one edge (add-then-shift step).
REQ-024 done SHALL go high on the edge where count reaches W, i.e. registered with count, zero added latency.
REQ-025 With done=1, shift SHALL be ignored: no data shift, count saturates at W; loads SHALL still apply.
REQ-026 count SHALL never exceed W or wrap.
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 clear_n=0 SHALL immediately force out=0, count=0, done=0, independent of clk.
REQ-029 Assertion of clear_n mid-sequence SHALL abandon the sequence; after release, state holds until the next load/start.
REQ-030 First active edge after clear_n deasserts SHALL obey REQ-017 normally.

Verification (W=8)
REQ-031 Load: loadh=1 inh=0xA5, loadl=1 inl=0x3C -> out=0xA53C; next loadl=1 inl=0xFF only -> out=0xA5FF.
REQ-032 Shift fill: out=0x0001, shift=1, cin=1, SIGNED=0 -> out=0x8000, count=1; SIGNED=1 instance from 0x8000, shift -> out=0xC000.
REQ-033 Combined: out=0x0003, loadh=1 inh=0x12, shift=1, cin=0 -> out=0x0901.
REQ-034 Counting: start, then 8 shift cycles -> count=8, done=1 on 8th edge; 9th shift -> out and count unchanged.
REQ-035 Priority: sclr=1 with loadh=1 inh=0xFF, shift=1 -> out=0x0000, count=0, done=0; start with shift=1 -> no shift, count=0.
REQ-036 Async reset: clear_n low between edges at count=5, out=0x1234 -> out=0, count=0, done=0 before next edge.
